// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch buffer; entry e0 is always the head, so the output needs no read mux.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t e0, e1;
  logic [1:0]   cnt;
  logic         do_pop, do_push;

  always_comb begin
    do_pop  = pop && (cnt != 2'd0);
    do_push = push && ((cnt != 2'd2) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case (cnt)
        2'd0: begin
          if (do_push) begin
            e0  <= push_data;
            cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (do_push && do_pop) begin
            e0 <= push_data;
          end else if (do_push) begin
            e1  <= push_data;
            cnt <= 2'd2;
          end else if (do_pop) begin
            cnt <= 2'd0;
          end
        end
        2'd2: begin
          if (do_pop) begin
            e0 <= e1;
            if (do_push) e1  <= push_data;
            else         cnt <= 2'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign head  = e0;
  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, RUN/HALT control, memory read port and prefetch buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 500,
  parameter logic [15:0] RESET_PC  = 16'd0,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        fault
);

  localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < PC_LIMIT;
  endfunction

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              fault_q;
  logic              fetch;
  logic [1:0]        count;
  fetch_entry_t      head, push_data;

  // Fetch depends only on registered state and redirect, never on instr_ready.
  always_comb begin
    fetch = rst_n && (state == RUN) && (count < 2'(DEPTH)) && !redirect && in_range(pc);
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect) begin
      pc_next    = redirect_pc;
      state_next = in_range(redirect_pc) ? RUN : HALT;
    end else begin
      if (fetch) pc_next = pc + 16'd1;
      if ((state == RUN) && !in_range(pc)) state_next = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      pc      <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      fault_q <= (state == HALT);
    end
  end

  assign push_data = '{word: mem_data, pc: pc};

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (fetch),
    .push_data (push_data),
    .pop       (instr_valid && instr_ready),
    .head      (head),
    .count     (count)
  );

  assign mem_addr    = pc;
  assign mem_re      = fetch;
  assign mem_we      = 1'b0;
  assign instr       = head.word;
  assign instr_pc    = head.pc;
  assign instr_valid = (count != 2'd0);
  assign fault       = fault_q;

endmodule
